obi_mem_responder: RTL

Subordinate (responder) end of the OBI-style req/gnt/rvalid memory protocol driven by the core's instruction and data ports. It holds a word-addressed on-chip memory, grants requests after a programmable wait, and returns in-order responses through a fixed-latency pipeline. One instance serves the instruction port and one serves the data port in the SoC top and in simulation benches. Out-of-range accesses produce an error response instead of touching memory.

---
 rtl/obi_mem_responder_if.sv | 22 ++
 rtl/obi_mem_responder.sv | 77 +++++++
 2 files changed

// File: rtl/obi_mem_responder_if.sv
// OBI-style req/gnt/rvalid bus between a core port (master) and a memory responder (slave).
interface obi_mem_responder_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/obi_mem_responder.sv
// Word-addressed memory responder: grants after GNT_WAIT cycles, answers through a
// RESP_LATENCY-deep in-order pipeline; out-of-range accesses return err without touching memory.
module obi_mem_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0002_0000,
  parameter int          DEPTH_WORDS  = 4096,
  parameter int          GNT_WAIT     = 0,
  parameter int          RESP_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  obi_mem_responder_if.slave   bus
);
  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [3:0]       wcnt;
  logic             in_range;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;

  logic             pipe_vld [RESP_LATENCY];
  logic             pipe_err [RESP_LATENCY];
  logic [31:0]      pipe_dat [RESP_LATENCY];

  // 33-bit compare so the window end cannot wrap past 2^32.
  assign in_range = ({1'b0, bus.addr_i} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, bus.addr_i} <  END_ADDR);
  assign offset   = bus.addr_i - BASE_ADDR;
  assign idx      = IDX_W'(offset >> 2);

  assign bus.gnt_o = bus.req_i && (wcnt == 4'(GNT_WAIT)) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt <= 4'd0;
    end else if (!bus.req_i || bus.gnt_o) begin
      wcnt <= 4'd0;
    end else begin
      wcnt <= wcnt + 4'd1;
    end
  end

  // Memory is deliberately left without reset so writes survive a core reset.
  always_ff @(posedge clk_i) begin
    if (bus.gnt_o && bus.we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) begin
          mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RESP_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_err[i] <= 1'b0;
        pipe_dat[i] <= 32'd0;
      end
    end else begin
      pipe_vld[0] <= bus.gnt_o;
      pipe_err[0] <= bus.gnt_o && !in_range;
      pipe_dat[0] <= (bus.gnt_o && !bus.we_i && in_range) ? mem[idx] : 32'd0;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign bus.rvalid_o = pipe_vld[RESP_LATENCY-1];
  assign bus.err_o    = pipe_err[RESP_LATENCY-1];
  assign bus.rdata_o  = pipe_dat[RESP_LATENCY-1];
endmodule
